// File: rtl/frv_leak_fence_seq_pkg.sv
// Shared constants for the leakage-fence sequencer: FSM encoding, LFSR taps, defaults.
package frv_leak_pkg;

    localparam int unsigned LKGCFG_W = 13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [31:0] PRNG_SEED_DEFAULT = 32'hABCDEF37;

    localparam int unsigned TAP_A = 31;
    localparam int unsigned TAP_B = 21;
    localparam int unsigned TAP_C = 1;
    localparam int unsigned TAP_D = 0;

endpackage

// File: rtl/frv_leak_fence_seq_if.sv
// Scrub-write handshake bus between the fence sequencer and the register-group targets.
interface frv_leak_fence_seq_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SEL_W = 3
);
    logic             scrub_valid;
    logic             scrub_ready;
    logic [SEL_W-1:0] scrub_sel;
    logic [XLEN-1:0]  scrub_data;

    modport master (output scrub_valid, scrub_sel, scrub_data, input scrub_ready);
    modport slave  (input scrub_valid, scrub_sel, scrub_data, output scrub_ready);
endinterface

// File: rtl/frv_leak_fence_seq_lfsr.sv
// 32-bit Fibonacci LFSR used as the scrub-data PRNG; reads as zero in weak mode.
module frv_leak_lfsr
    import frv_leak_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter logic [31:0] SEED   = PRNG_SEED_DEFAULT,
    parameter bit          STRONG = 1'b1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            step,
    output logic [XLEN-1:0] prng
);

    logic [XLEN-1:0] q;
    logic            lsb;

    assign lsb = ((q[TAP_A] ~^ q[TAP_B]) ~^ q[TAP_C]) ~^ q[TAP_D];

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            q <= XLEN'(SEED);
        end else if (step) begin
            q <= {q[XLEN-2:0], lsb};
        end
    end

    // Weak mode leaves the register dangling so synthesis prunes it.
    assign prng = STRONG ? q : '0;

endmodule

// File: rtl/frv_leak_fence_seq.sv
// Leakage-fence sequencer: owns lkgcfg and the PRNG, scrubs each enabled group once per fence.
module frv_leak_fence_seq
    import frv_leak_pkg::*;
#(
    parameter int unsigned           XLEN         = 32,
    parameter int unsigned           NUM_GROUPS   = 8,
    parameter int unsigned           SEL_W        = 3,
    parameter bit                    STRONG       = 1'b1,
    parameter logic [LKGCFG_W-1:0]   LKGCFG_RESET = 13'b0,
    parameter logic [31:0]           PRNG_SEED    = 32'hABCDEF37
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    input  logic                 cfg_load,
    input  logic [XLEN-1:0]      cfg_wdata,
    output logic [LKGCFG_W-1:0]  lkgcfg,
    output logic [XLEN-1:0]      prng,
    input  logic                 fence_req,
    output logic                 fence_ack,
    output logic                 busy,
    frv_leak_fence_seq_if.master scrub
);

    localparam int unsigned XL = XLEN - 1;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [NUM_GROUPS-1:0] rem;
    logic [NUM_GROUPS-1:0] rem_nxt;
    logic [NUM_GROUPS-1:0] rem_cleared;
    logic [NUM_GROUPS-1:0] cfg_mask;
    logic [SEL_W-1:0]      sel_c;
    logic                  step;
    logic                  unused_cfg_hi;

    assign unused_cfg_hi = ^cfg_wdata[XL:LKGCFG_W];
    assign cfg_mask      = lkgcfg[NUM_GROUPS-1:0];
    assign rem_cleared   = rem & (rem - NUM_GROUPS'(1));

    frv_leak_lfsr #(
        .XLEN   (XLEN),
        .SEED   (PRNG_SEED),
        .STRONG (STRONG)
    ) u_lfsr (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .step    (step),
        .prng    (prng)
    );

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            lkgcfg <= LKGCFG_RESET;
        end else if (cfg_load) begin
            lkgcfg <= cfg_wdata[LKGCFG_W-1:0];
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= ST_IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Lowest-set-bit priority encoder over the remaining mask.
    always_comb begin
        sel_c = '0;
        for (int i = int'(NUM_GROUPS) - 1; i >= 0; i--) begin
            if (rem[i]) sel_c = SEL_W'(i);
        end
    end

    always_comb begin
        state_nxt         = state;
        rem_nxt           = rem;
        step              = 1'b0;
        busy              = 1'b0;
        fence_ack         = 1'b0;
        scrub.scrub_valid = 1'b0;
        scrub.scrub_sel   = '0;
        scrub.scrub_data  = '0;
        case (state)
            ST_IDLE: begin
                // Snapshot uses the pre-load lkgcfg, so a same-cycle cfg_load hits the next fence.
                if (fence_req) begin
                    rem_nxt   = cfg_mask;
                    step      = 1'b1;
                    state_nxt = (|cfg_mask) ? ST_SCAN : ST_ACK;
                end
            end
            ST_SCAN: begin
                busy              = 1'b1;
                scrub.scrub_valid = 1'b1;
                scrub.scrub_sel   = sel_c;
                scrub.scrub_data  = prng;
                if (scrub.scrub_ready) begin
                    rem_nxt = rem_cleared;
                    step    = 1'b1;
                    if (rem_cleared == '0) state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                busy      = 1'b1;
                fence_ack = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frv_leak_fence_seq.sv
// Scoreboard bench for frv_leak_fence_seq: stimulus queues expected scrubs/acks, a monitor checks them.
module tb_frv_leak_fence_seq;
    import frv_leak_pkg::*;

    localparam logic [31:0] SEED = 32'hABCDEF37;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        cfg_load = 1'b0;
    logic [31:0] cfg_wdata = '0;
    logic [12:0] lkgcfg;
    logic [31:0] prng;
    logic        fence_req = 1'b0;
    logic        fence_ack;
    logic        busy;

    frv_leak_fence_seq_if #(.XLEN(32), .SEL_W(3)) sbus ();

    frv_leak_fence_seq #(
        .XLEN(32), .NUM_GROUPS(8), .SEL_W(3), .STRONG(1'b1),
        .LKGCFG_RESET(13'b0), .PRNG_SEED(SEED)
    ) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .cfg_load  (cfg_load),
        .cfg_wdata (cfg_wdata),
        .lkgcfg    (lkgcfg),
        .prng      (prng),
        .fence_req (fence_req),
        .fence_ack (fence_ack),
        .busy      (busy),
        .scrub     (sbus)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] data;
    } scrub_t;

    scrub_t      exp_q[$];
    int          ack_q[$];
    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] mp;
    scrub_t      mon_e;
    int          mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] p);
        return {p[30:0], ((p[31] ~^ p[21]) ~^ p[1]) ~^ p[0]};
    endfunction

    // Monitor: pop expectations whenever the DUT completes a scrub handshake or acks.
    always @(negedge g_clk) begin
        if (!g_reset) begin
            if (sbus.scrub_valid && sbus.scrub_ready) begin
                if (exp_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL scrub_unexpected: got sel %0d data 0x%08h expected no scrub",
                             sbus.scrub_sel, sbus.scrub_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("scrub_sel", 32'(sbus.scrub_sel), 32'(mon_e.sel));
                    check("scrub_data", sbus.scrub_data, mon_e.data);
                end
            end
            if (fence_ack) begin
                if (ack_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL ack_unexpected: got fence_ack at cycle %0d expected none", cyc);
                end else begin
                    mon_a = ack_q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(mon_a));
                end
            end
        end
    end

    task automatic expect_fence(input logic [12:0] mask, input int a_cyc, input int stalls);
        int     k = 0;
        scrub_t e;
        mp = lfsr_next(mp);
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                e.sel  = 3'(i);
                e.data = mp;
                exp_q.push_back(e);
                mp = lfsr_next(mp);
                k++;
            end
        end
        ack_q.push_back(a_cyc + k + stalls);
    endtask

    task automatic do_reset();
        @(posedge g_clk); #1 g_reset = 1'b1;
        @(posedge g_clk); #1;
        @(posedge g_clk); #1 g_reset = 1'b0;
        mp = SEED;
    endtask

    task automatic load_cfg(input logic [12:0] v);
        @(posedge g_clk); #1 cfg_load = 1'b1; cfg_wdata = 32'(v);
        @(posedge g_clk); #1 cfg_load = 1'b0;
        check("lkgcfg_load", 32'(lkgcfg), 32'(v));
    endtask

    // One-cycle request; optional cfg_load in the same cycle. Returns at acceptance+1.
    task automatic start_fence(input logic [12:0] mask, input int stalls,
                               input bit cl, input logic [12:0] cw);
        int a;
        @(posedge g_clk); #1;
        a = cyc + 1;
        expect_fence(mask, a, stalls);
        fence_req = 1'b1;
        cfg_load  = cl;
        cfg_wdata = 32'(cw);
        @(posedge g_clk); #1 fence_req = 1'b0; cfg_load = 1'b0;
    endtask

    task automatic wait_ack();
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge g_clk);
            n++;
            check("busy_in_fence", 32'(busy), 32'd1);
            if (fence_ack) seen = 1'b1;
        end
        if (!seen) begin
            nchk++; nerr++;
            $display("FAIL ack_timeout: got no fence_ack in 40 cycles expected one");
        end
    endtask

    initial begin
        sbus.scrub_ready = 1'b1;
        mp = SEED;
        repeat (3) @(posedge g_clk);
        #1 g_reset = 1'b0;

        // Reset state
        @(negedge g_clk);
        check("rst_prng", prng, 32'hABCDEF37);
        check("rst_lkgcfg", 32'(lkgcfg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(sbus.scrub_valid), 32'd0);
        check("rst_ack", 32'(fence_ack), 32'd0);
        check("rst_data", sbus.scrub_data, 32'd0);

        // Empty mask: straight to ack
        start_fence(13'h000, 0, 1'b0, 13'h0);
        wait_ack();
        @(negedge g_clk);
        check("k0_prng", prng, 32'h579BDE6E);
        check("k0_idle_busy", 32'(busy), 32'd0);

        // Four groups, no stalls
        do_reset();
        load_cfg(13'h0A5);
        start_fence(13'h0A5, 0, 1'b0, 13'h0);
        wait_ack();
        @(negedge g_clk);
        check("a5_prng_after", prng, mp);

        // Stall on group 0 for three cycles
        do_reset();
        load_cfg(13'h003);
        sbus.scrub_ready = 1'b0;
        start_fence(13'h003, 3, 1'b0, 13'h0);
        for (int s = 0; s < 3; s++) begin
            @(negedge g_clk);
            check("stall_valid", 32'(sbus.scrub_valid), 32'd1);
            check("stall_sel", 32'(sbus.scrub_sel), 32'd0);
            check("stall_data", sbus.scrub_data, 32'h579BDE6E);
            if (s < 2) begin
                @(posedge g_clk); #1;
            end
        end
        @(posedge g_clk); #1 sbus.scrub_ready = 1'b1;
        wait_ack();

        // cfg_load in the acceptance cycle only affects the next fence
        do_reset();
        load_cfg(13'h004);
        start_fence(13'h004, 0, 1'b1, 13'h001);
        check("samecyc_lkgcfg", 32'(lkgcfg), 32'h001);
        wait_ack();
        start_fence(13'h001, 0, 1'b0, 13'h0);
        wait_ack();

        // Reset mid-SCAN aborts without ack
        do_reset();
        load_cfg(13'h0FF);
        sbus.scrub_ready = 1'b0;
        @(posedge g_clk); #1 fence_req = 1'b1;
        @(posedge g_clk); #1 fence_req = 1'b0;
        @(negedge g_clk);
        check("abort_in_scan", 32'(sbus.scrub_valid), 32'd1);
        @(posedge g_clk); #1 g_reset = 1'b1;
        @(posedge g_clk); #1 g_reset = 1'b0;
        @(negedge g_clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(sbus.scrub_valid), 32'd0);
        check("abort_ack", 32'(fence_ack), 32'd0);
        check("abort_prng", prng, 32'hABCDEF37);
        check("abort_lkgcfg", 32'(lkgcfg), 32'd0);
        sbus.scrub_ready = 1'b1;
        repeat (5) @(negedge g_clk);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("ack_q_drained", 32'(ack_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
